// File: rtl/cp0_ctrl.sv
// Coprocessor-0 register block for the five-stage MIPS pipeline: BadVAddr, Count,
// Compare, Status, Cause and EPC, plus the exception/eret flush sequencing.
module cp0_ctrl #(
    parameter logic [31:0] EX_ENTRY   = 32'hBFC0_0380,
    parameter logic [31:0] STATUS_RST = 32'h0040_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_ex,
    input  logic [4:0]  wb_excode,
    input  logic [31:0] wb_badvaddr,
    input  logic        wb_bd,
    input  logic [31:0] wb_pc,
    input  logic        wb_eret,
    input  logic        mtc0_we,
    input  logic [4:0]  cp0_addr,
    input  logic [31:0] mtc0_wdata,
    input  logic [5:0]  ext_int_in,
    output logic [31:0] cp0_rdata,
    output logic        flush,
    output logic [31:0] flush_pc,
    output logic        has_int,
    output logic [31:0] epc_out
);

    localparam logic [4:0] ADDR_BADVADDR = 5'd8;
    localparam logic [4:0] ADDR_COUNT    = 5'd9;
    localparam logic [4:0] ADDR_COMPARE  = 5'd11;
    localparam logic [4:0] ADDR_STATUS   = 5'd12;
    localparam logic [4:0] ADDR_CAUSE    = 5'd13;
    localparam logic [4:0] ADDR_EPC      = 5'd14;

    logic [31:0] r_badvaddr;
    logic [31:0] r_count;
    logic [31:0] r_compare;
    logic [31:0] r_epc;
    logic [7:0]  r_im;
    logic        r_exl;
    logic        r_ie;
    logic        r_bd;
    logic        r_ti;
    logic [1:0]  r_ip_sw;
    logic [4:0]  r_excode;
    logic        r_tick;

    logic        w_ev_eret;
    logic        w_ev_mtc0;
    logic        w_wr_count;
    logic        w_wr_compare;
    logic        w_wr_status;
    logic        w_wr_cause;
    logic        w_wr_epc;
    logic        w_addr_exc;
    logic [7:0]  w_ip;
    logic [31:0] w_status;
    logic [31:0] w_cause;

    // Exception beats eret beats mtc0; the losers in a cycle are simply dropped.
    assign w_ev_eret    = ~wb_ex & wb_eret;
    assign w_ev_mtc0    = ~wb_ex & ~wb_eret & mtc0_we;
    assign w_wr_count   = w_ev_mtc0 && (cp0_addr == ADDR_COUNT);
    assign w_wr_compare = w_ev_mtc0 && (cp0_addr == ADDR_COMPARE);
    assign w_wr_status  = w_ev_mtc0 && (cp0_addr == ADDR_STATUS);
    assign w_wr_cause   = w_ev_mtc0 && (cp0_addr == ADDR_CAUSE);
    assign w_wr_epc     = w_ev_mtc0 && (cp0_addr == ADDR_EPC);
    assign w_addr_exc   = (wb_excode == 5'd4) || (wb_excode == 5'd5);

    // Hardware interrupt lines are level sensitive and not latched; the timer
    // interrupt shares IP7 with the highest external line.
    assign w_ip     = {ext_int_in[5] | r_ti, ext_int_in[4:0], r_ip_sw};
    assign w_status = {9'b0, 1'b1, 6'b0, r_im, 6'b0, r_exl, r_ie};
    assign w_cause  = {r_bd, r_ti, 14'b0, w_ip, 1'b0, r_excode, 2'b0};

    always_comb begin
        cp0_rdata = 32'b0;
        case (cp0_addr)
            ADDR_BADVADDR: cp0_rdata = r_badvaddr;
            ADDR_COUNT:    cp0_rdata = r_count;
            ADDR_COMPARE:  cp0_rdata = r_compare;
            ADDR_STATUS:   cp0_rdata = w_status;
            ADDR_CAUSE:    cp0_rdata = w_cause;
            ADDR_EPC:      cp0_rdata = r_epc;
            default:       cp0_rdata = 32'b0;
        endcase
    end

    assign flush    = wb_ex | wb_eret;
    assign flush_pc = wb_ex ? EX_ENTRY : r_epc;
    assign has_int  = (|(w_ip & r_im)) & r_ie & ~r_exl;
    assign epc_out  = r_epc;

    // Count advances every other cycle; a software write wins over the increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tick  <= 1'b0;
            r_count <= 32'b0;
        end else begin
            r_tick <= ~r_tick;
            if (w_wr_count) begin
                r_count <= mtc0_wdata;
            end else if (r_tick) begin
                r_count <= r_count + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_compare <= 32'b0;
            r_ti      <= 1'b0;
        end else begin
            if (w_wr_compare) begin
                r_compare <= mtc0_wdata;
                r_ti      <= 1'b0;
            end else if (r_count == r_compare) begin
                r_ti <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_im  <= STATUS_RST[15:8];
            r_exl <= STATUS_RST[1];
            r_ie  <= STATUS_RST[0];
        end else if (wb_ex) begin
            r_exl <= 1'b1;
        end else if (w_ev_eret) begin
            r_exl <= 1'b0;
        end else if (w_wr_status) begin
            r_im  <= mtc0_wdata[15:8];
            r_exl <= mtc0_wdata[1];
            r_ie  <= mtc0_wdata[0];
        end
    end

    // A nested exception (EXL already set) must not overwrite the return state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_epc    <= 32'b0;
            r_bd     <= 1'b0;
            r_excode <= 5'b0;
            r_ip_sw  <= 2'b0;
        end else if (wb_ex) begin
            r_excode <= wb_excode;
            if (!r_exl) begin
                r_epc <= wb_bd ? (wb_pc - 32'd4) : wb_pc;
                r_bd  <= wb_bd;
            end
        end else if (w_wr_epc) begin
            r_epc <= mtc0_wdata;
        end else if (w_wr_cause) begin
            r_ip_sw <= mtc0_wdata[9:8];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_badvaddr <= 32'b0;
        end else if (wb_ex && w_addr_exc) begin
            r_badvaddr <= wb_badvaddr;
        end
    end

endmodule

// File: tb/tb_cp0_ctrl.sv
// Directed bench for cp0_ctrl: expected values are queued as each step is driven
// and popped when the corresponding DUT output is sampled.
module tb_cp0_ctrl;

    logic        clk;
    logic        reset;
    logic        wb_ex;
    logic [4:0]  wb_excode;
    logic [31:0] wb_badvaddr;
    logic        wb_bd;
    logic [31:0] wb_pc;
    logic        wb_eret;
    logic        mtc0_we;
    logic [4:0]  cp0_addr;
    logic [31:0] mtc0_wdata;
    logic [5:0]  ext_int_in;
    logic [31:0] cp0_rdata;
    logic        flush;
    logic [31:0] flush_pc;
    logic        has_int;
    logic [31:0] epc_out;

    int n_tests;
    int n_fail;

    logic [31:0] exp_q[$];
    string       tag_q[$];

    cp0_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .wb_ex      (wb_ex),
        .wb_excode  (wb_excode),
        .wb_badvaddr(wb_badvaddr),
        .wb_bd      (wb_bd),
        .wb_pc      (wb_pc),
        .wb_eret    (wb_eret),
        .mtc0_we    (mtc0_we),
        .cp0_addr   (cp0_addr),
        .mtc0_wdata (mtc0_wdata),
        .ext_int_in (ext_int_in),
        .cp0_rdata  (cp0_rdata),
        .flush      (flush),
        .flush_pc   (flush_pc),
        .has_int    (has_int),
        .epc_out    (epc_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic expect_val(input string tag, input logic [31:0] exp);
        tag_q.push_back(tag);
        exp_q.push_back(exp);
    endtask

    task automatic check_next(input logic [31:0] obs);
        string       tag;
        logic [31:0] exp;
        tag = tag_q.pop_front();
        exp = exp_q.pop_front();
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("[TB] %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic read_check(input string tag, input logic [4:0] addr, input logic [31:0] exp);
        cp0_addr = addr;
        expect_val(tag, exp);
        #1;
        check_next(cp0_rdata);
    endtask

    task automatic do_mtc0(input logic [4:0] addr, input logic [31:0] data);
        @(negedge clk);
        mtc0_we    = 1'b1;
        cp0_addr   = addr;
        mtc0_wdata = data;
        @(posedge clk);
        #1;
        mtc0_we = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset = 1'b1;
        wb_ex = 1'b0; wb_excode = 5'd0; wb_badvaddr = 32'd0; wb_bd = 1'b0;
        wb_pc = 32'd0; wb_eret = 1'b0; mtc0_we = 1'b0; cp0_addr = 5'd0;
        mtc0_wdata = 32'd0; ext_int_in = 6'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Reset state, before the first active edge.
        read_check("rst_status", 5'd12, 32'h0040_0000);
        read_check("rst_cause", 5'd13, 32'h0000_0000);
        read_check("rst_count", 5'd9, 32'h0000_0000);
        read_check("rst_epc", 5'd14, 32'h0000_0000);
        read_check("rst_unmapped", 5'd3, 32'h0000_0000);
        expect_val("rst_flush", 32'd0);
        check_next({31'd0, flush});
        expect_val("rst_has_int", 32'd0);
        check_next({31'd0, has_int});

        // Count==Compare==0 sets TI at the first edge; TI also shows as IP7.
        @(posedge clk);
        #1;
        cp0_addr = 5'd13;
        expect_val("ti_after_rst", 32'h4000_0000);
        #1;
        check_next(cp0_rdata & 32'h4000_0000);
        expect_val("ip7_after_rst", 32'h0000_8000);
        check_next(cp0_rdata & 32'h0000_8000);

        // Compare write clears TI; restart Count and enable IM7 + IE.
        do_mtc0(5'd11, 32'd10);
        read_check("ti_cleared", 5'd13, 32'h0000_0000);
        read_check("compare_rd", 5'd11, 32'd10);
        do_mtc0(5'd9, 32'd0);
        read_check("count_written", 5'd9, 32'd0);
        do_mtc0(5'd12, 32'h0000_8001);
        read_check("status_written", 5'd12, 32'h0040_8001);

        cp0_addr = 5'd13;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (cp0_rdata[30]) break;
        end
        #1;
        expect_val("timer_ti", 32'h4000_8000);
        check_next(cp0_rdata & 32'h4000_8000);
        expect_val("timer_has_int", 32'd1);
        check_next({31'd0, has_int});

        do_mtc0(5'd11, 32'd10);
        read_check("ti_recleared", 5'd13, 32'h0000_0000);
        expect_val("has_int_cleared", 32'd0);
        check_next({31'd0, has_int});
        do_mtc0(5'd11, 32'hFFFF_0000);

        // Address-error exception in a delay slot.
        @(negedge clk);
        wb_ex = 1'b1; wb_excode = 5'd4; wb_pc = 32'hBFC0_1000; wb_bd = 1'b1;
        wb_badvaddr = 32'h1234_5671;
        #1;
        expect_val("ex1_flush", 32'd1);
        check_next({31'd0, flush});
        expect_val("ex1_flush_pc", 32'hBFC0_0380);
        check_next(flush_pc);
        @(posedge clk);
        #1;
        wb_ex = 1'b0;
        read_check("ex1_epc", 5'd14, 32'hBFC0_0FFC);
        read_check("ex1_cause", 5'd13, 32'h8000_0010);
        read_check("ex1_badvaddr", 5'd8, 32'h1234_5671);
        read_check("ex1_status", 5'd12, 32'h0040_8003);
        expect_val("ex1_epc_out", 32'hBFC0_0FFC);
        check_next(epc_out);

        // Nested exception while EXL=1: return state preserved.
        @(negedge clk);
        wb_ex = 1'b1; wb_excode = 5'd8; wb_pc = 32'h1000_0000; wb_bd = 1'b0;
        wb_badvaddr = 32'hAAAA_AAAA;
        @(posedge clk);
        #1;
        wb_ex = 1'b0;
        read_check("ex2_epc", 5'd14, 32'hBFC0_0FFC);
        read_check("ex2_cause", 5'd13, 32'h8000_0020);
        read_check("ex2_badvaddr", 5'd8, 32'h1234_5671);

        @(negedge clk);
        wb_eret = 1'b1;
        #1;
        expect_val("eret_flush", 32'd1);
        check_next({31'd0, flush});
        expect_val("eret_flush_pc", 32'hBFC0_0FFC);
        check_next(flush_pc);
        @(posedge clk);
        #1;
        wb_eret = 1'b0;
        read_check("eret_status", 5'd12, 32'h0040_8001);

        // Exception and mtc0 EPC in the same cycle: the write is lost.
        @(negedge clk);
        wb_ex = 1'b1; wb_excode = 5'd12; wb_pc = 32'h0040_0010; wb_bd = 1'b0;
        mtc0_we = 1'b1; cp0_addr = 5'd14; mtc0_wdata = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        wb_ex = 1'b0; mtc0_we = 1'b0;
        read_check("prio_epc", 5'd14, 32'h0040_0010);
        read_check("prio_cause", 5'd13, 32'h0000_0030);

        // Asynchronous reset between edges.
        do_mtc0(5'd9, 32'h55);
        read_check("count_55", 5'd9, 32'h0000_0055);
        #1;
        reset = 1'b1;
        #1;
        read_check("areset_count", 5'd9, 32'h0000_0000);
        read_check("areset_status", 5'd12, 32'h0040_0000);
        read_check("areset_epc", 5'd14, 32'h0000_0000);
        @(negedge clk);
        reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
